rr_lock_arbiter: RTL and testbench
==================================

// Module: rr_lock_arbiter
// PURPOSE
//  N-requester arbiter with registered one-hot grant; selectable fixed-priority or round-robin mode.
//  Owner keeps the grant (lock) while it requests; a starvation limit forces hand-over after MAX_HOLD cycles.
//  Sits between requesting masters and a shared resource; drives the grant bus sampled by arb_if-style benches.
// PARAMETERS
//  NUM_REQ   4                          number of requesters (>=2)
//  MAX_HOLD  8                          max consecutive grant cycles while others wait; 0 = unlimited
//  ID_W      $clog2(NUM_REQ)            width of grant_id
//  HOLD_W    $clog2(MAX_HOLD+1) (min 1) width of hold counter
// PORTS
//  clk          in   1        single clock, all state on posedge
//  reset        in   1        asynchronous, active-low reset
//  mode         in   1        0 = fixed priority (index 0 highest), 1 = round-robin
//  request      in   NUM_REQ  level request per requester
//  grant        out  NUM_REQ  registered one-hot grant, all-zero when idle
//  grant_valid  out  1        |grant, registered
//  grant_id     out  ID_W     binary index of granted requester; 0 when idle
// BEHAVIOUR
//  Reset (reset low, async): grant=0, grant_valid=0, grant_id=0, hold_cnt=0, last_ptr=NUM_REQ-1, state=IDLE.
//  Latency: request sampled at edge k -> grant visible after edge k (1 cycle); no combinational req->grant path.
//  FSM: IDLE, OWNED.
//   IDLE : no request -> IDLE. Any request -> OWNED, grant winner, hold_cnt=1.
//   OWNED: request[owner]=1 and not preempt -> stay; hold_cnt++ (saturates at MAX_HOLD).
//          request[owner]=0 -> re-arbitrate same edge: winner among others -> new owner, hold_cnt=1
//          (no bubble); none -> IDLE, grant=0.
//          preempt = MAX_HOLD!=0 && hold_cnt==MAX_HOLD && some other request=1:
//          owner excluded, grant moves to winner among others, hold_cnt=1.
//  Winner select: fixed mode = lowest requesting index; RR = first requesting index after last_ptr, wrapping
//   NUM_REQ-1 -> 0. last_ptr <= winner on every new grant (both modes).
//  Owner holds exactly MAX_HOLD cycles under contention; alone it holds indefinitely (hold_cnt saturates).
//  mode is sampled only at arbitration edges; change mid-ownership does not disturb the current owner.
//  grant always one-hot or zero; grant_id/grant_valid consistent with grant every cycle.
//  Reset asserted mid-ownership: outputs clear immediately (async); first arbitration after release uses last_ptr=NUM_REQ-1.
//  Requests for non-owners arriving/dropping mid-ownership have no effect until next arbitration edge.
// STRUCTURE
//  Package arb_pkg: typedef enum logic {ARB_FIXED=1'b0, ARB_RR=1'b1} arb_mode_e;
//   typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_e; shared with bench/interface.
//  Sub-module arb_prio_pick #(N): combinational pick of first set bit of req at/after start index with
//   wrap; outputs one-hot + index + found. Fixed mode drives start=0; RR drives start=last_ptr+1 (mod N).
//  Top: FSM, hold counter, last_ptr, masked request vector (owner bit cleared on preempt/release).
// TESTING (NUM_REQ=4, MAX_HOLD=4 unless noted)
//  Reset: reset low with request=4'b1111 -> grant=0, grant_valid=0, grant_id=0; release -> next edge grant=4'b0001.
//  RR rotation: request=4'b1111, each owner drops req after 1 cycle -> grants 0001,0010,0100,1000,0001, no idle bubble.
//  Fixed priority: mode=0, request=4'b1010, owner drops after 1 cycle -> 0010 repeatedly while bit1 re-requests.
//  Preempt: request[2] held, request[0] raised -> grant=0100 exactly 4 cycles, then 0001; lone request[2] held 20 cycles -> never preempted.
//  Wrap/idle: last owner 3, request=0 for 3 cycles -> grant=0; then request=4'b1001 in RR -> 0001.
//  Async reset mid-ownership (grant=0100): pull reset low between edges -> grant=0 before next posedge.

Source files
------------

// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types for the lock-holding arbiter: mode and FSM state encodings,
// plus a width helper used for the hold counter.
package arb_pkg;

    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_OWNED = 1'b1} arb_state_e;

    // Bit width needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/rr_lock_arbiter_pick.sv
// Combinational priority pick: first set request bit at or after the start
// index, wrapping from N-1 back to 0.
module arb_prio_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(start) + i) % N;
            if (!found && req[j[IW-1:0]]) begin
                found               = 1'b1;
                onehot[j[IW-1:0]]   = 1'b1;
                idx                 = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way arbiter with a registered one-hot grant. The owner keeps the grant while
// it requests, unless it has held MAX_HOLD cycles while someone else is waiting.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int HOLD_W   = clog2_min1(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [NUM_REQ-1:0] request,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    localparam logic [ID_W-1:0]   LAST_IDX = ID_W'(NUM_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e         state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [ID_W-1:0]    last_ptr_q, last_ptr_d;
    logic [ID_W-1:0]    start, pick_idx, id_d;
    logic [NUM_REQ-1:0] masked_req, pick_onehot, grant_d;
    logic               pick_found, owner_req, hold_full, preempt, valid_d, arbitrate;

    // The owner is always excluded from arbitration; when idle grant is zero so
    // this is simply the raw request vector.
    assign masked_req = request & ~grant;
    assign owner_req  = |(request & grant);
    assign hold_full  = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
    assign preempt    = hold_full && (|masked_req);
    assign start      = (arb_mode_e'(mode) == ARB_FIXED) ? '0 :
                        (last_ptr_q == LAST_IDX)         ? '0 : last_ptr_q + 1'b1;

    arb_prio_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req    (masked_req),
        .start  (start),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant;
        valid_d    = grant_valid;
        id_d       = grant_id;
        hold_d     = hold_q;
        last_ptr_d = last_ptr_q;
        arbitrate  = 1'b0;
        case (state_q)
            ARB_IDLE:  arbitrate = 1'b1;
            ARB_OWNED: begin
                if (owner_req && !preempt) begin
                    if ((MAX_HOLD != 0) && !hold_full)
                        hold_d = hold_q + 1'b1;
                end else begin
                    arbitrate = 1'b1;
                end
            end
            default:   arbitrate = 1'b1;
        endcase
        // Hand-over happens on the same edge the owner releases, so no idle bubble.
        if (arbitrate) begin
            if (pick_found) begin
                state_d    = ARB_OWNED;
                grant_d    = pick_onehot;
                valid_d    = 1'b1;
                id_d       = pick_idx;
                hold_d     = HOLD_W'(1);
                last_ptr_d = pick_idx;
            end else begin
                state_d = ARB_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                id_d    = '0;
                hold_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            hold_q      <= '0;
            last_ptr_q  <= LAST_IDX;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            grant_valid <= valid_d;
            grant_id    <= id_d;
            hold_q      <= hold_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (4 requesters, MAX_HOLD=4) with
// hand-computed grant sequences.
module tb_rr_lock_arbiter;
    import arb_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 4;
    localparam int ID_W     = 2;

    logic               clk;
    logic               reset;
    logic               mode;
    logic [NUM_REQ-1:0] request;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;

    int tests_run    = 0;
    int tests_failed = 0;

    rr_lock_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .request     (request),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Checks grant plus the grant_valid/grant_id that must accompany it.
    task automatic checkGrant(input string tag, input logic [NUM_REQ-1:0] exp_grant);
        logic [31:0] exp_id;
        exp_id = 0;
        for (int i = 0; i < NUM_REQ; i++)
            if (exp_grant[i]) exp_id = i;
        checkOutput({tag, ".grant"}, 32'(grant), 32'(exp_grant));
        checkOutput({tag, ".valid"}, 32'(grant_valid), 32'(|exp_grant));
        checkOutput({tag, ".id"}, 32'(grant_id), exp_id);
    endtask

    // Drive a request pattern, clock once, then sample just after the edge.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] req);
        request = req;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        mode    = ARB_RR;
        request = 4'b1111;
        #1;
        checkGrant("reset_async", 4'b0000);
        @(posedge clk);
        #1;
        checkGrant("reset_held", 4'b0000);
        reset = 1'b1;

        applyStimulus(4'b1111);
        checkGrant("reset_release", 4'b0001);

        // Round-robin rotation: each owner drops for one cycle, no bubble.
        applyStimulus(4'b1110);
        checkGrant("rr_1", 4'b0010);
        applyStimulus(4'b1101);
        checkGrant("rr_2", 4'b0100);
        applyStimulus(4'b1011);
        checkGrant("rr_3", 4'b1000);
        applyStimulus(4'b0111);
        checkGrant("rr_wrap", 4'b0001);

        // Fixed priority picks the lowest index where round-robin would not.
        mode = ARB_FIXED;
        applyStimulus(4'b1010);
        checkGrant("fix_1", 4'b0010);
        applyStimulus(4'b0000);
        checkGrant("fix_idle", 4'b0000);
        applyStimulus(4'b1010);
        checkGrant("fix_2", 4'b0010);
        applyStimulus(4'b1000);
        checkGrant("fix_drop", 4'b1000);
        applyStimulus(4'b0000);
        checkGrant("fix_idle2", 4'b0000);
        applyStimulus(4'b1010);
        checkGrant("fix_3", 4'b0010);

        // Idle after owner 3, then wrap to requester 0.
        mode = ARB_RR;
        applyStimulus(4'b1000);
        checkGrant("wrap_own3", 4'b1000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000);
            checkGrant("wrap_idle", 4'b0000);
        end
        applyStimulus(4'b1001);
        checkGrant("wrap_rr", 4'b0001);

        // Preemption: under contention each owner holds exactly four cycles.
        applyStimulus(4'b0010);
        checkGrant("pre_setup", 4'b0010);
        applyStimulus(4'b0101);
        checkGrant("pre_own2_0", 4'b0100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0101);
            checkGrant("pre_own2", 4'b0100);
        end
        applyStimulus(4'b0101);
        checkGrant("pre_to0", 4'b0001);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0101);
            checkGrant("pre_own0", 4'b0001);
        end
        applyStimulus(4'b0101);
        checkGrant("pre_back2", 4'b0100);

        // Lone owner never preempted; mode change mid-ownership has no effect.
        for (int i = 0; i < 20; i++) begin
            if (i == 10) mode = ARB_FIXED;
            applyStimulus(4'b0100);
            checkGrant("lone_hold", 4'b0100);
        end

        // Async reset between edges clears outputs before the next posedge.
        #3;
        reset = 1'b0;
        #1;
        checkGrant("mid_reset", 4'b0000);
        @(posedge clk);
        #1;
        checkGrant("mid_reset_held", 4'b0000);
        mode  = ARB_RR;
        reset = 1'b1;
        applyStimulus(4'b1010);
        checkGrant("post_reset_ptr", 4'b0010);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
